// File: rtl/output_buffer_stream_reader_pkg.sv
// Shared definitions for the output-buffer stream reader: default geometry,
// derived widths and the reader FSM state type.
package output_buffer_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_OUT_CHANNELS = 3;
  localparam int DEF_IN_WIDTH     = 5;
  localparam int DEF_IN_HEIGHT    = 5;

  localparam int NUM_PIXELS = DEF_IN_WIDTH * DEF_IN_HEIGHT;
  localparam int PIX_ADDR_W = $clog2(NUM_PIXELS);
  localparam int PIX_WORD_W = DEF_DATA_WIDTH * DEF_OUT_CHANNELS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  // Address width for a given pixel count; never collapses to zero bits.
  function automatic int addr_width(input int num_pix);
    return (num_pix < 2) ? 1 : $clog2(num_pix);
  endfunction

endpackage

// File: rtl/output_buffer_stream_reader_skid_fifo.sv
// Two-entry skid FIFO that absorbs the buffer's registered read latency.
// The head word is presented combinationally; push and pop may coincide.
module stream_skid_fifo #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_idx_q;
  logic             rd_idx_q;
  logic [1:0]       count_q;

  // Storage, ring indices and occupancy; all cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_idx_q] <= push_data;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_idx_q];
  assign count = count_q;

  overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == 2'd2)));

  underflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/output_buffer_stream_reader.sv
// Streams one frame out of the 1x1 output buffer: walks pixel addresses in
// order, issues reads only when the skid FIFO is guaranteed to have room,
// and presents each pixel word on a valid/ready interface.
module output_buffer_stream_reader
  import output_buffer_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int OUT_CHANNELS = DEF_OUT_CHANNELS,
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int IN_HEIGHT    = DEF_IN_HEIGHT
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  output logic [addr_width(IN_WIDTH*IN_HEIGHT)-1:0]     buf_rd_addr,
  output logic                                          buf_rd_en,
  input  logic [DATA_WIDTH*OUT_CHANNELS-1:0]            buf_rd_data,
  output logic [DATA_WIDTH*OUT_CHANNELS-1:0]            o_data,
  output logic                                          o_valid,
  input  logic                                          o_ready,
  output logic                                          o_last
);

  localparam int N_PIX  = IN_WIDTH * IN_HEIGHT;
  localparam int ADDR_W = addr_width(N_PIX);
  localparam int WORD_W = DATA_WIDTH * OUT_CHANNELS;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PIX - 1);

  reader_state_e     state_q;
  reader_state_e     state_d;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] beat_cnt_q;
  logic              inflight_q;

  logic [1:0]        fifo_count;
  logic [WORD_W-1:0] fifo_head;
  logic [2:0]        occupancy;
  logic              pop;
  logic              rd_issue;
  logic              last_addr;
  logic              last_beat;

  // A read is only issued if the word it returns is certain to find a FIFO slot.
  assign pop       = o_valid & o_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign rd_issue  = (state_q == RUN) && (occupancy < (3'd2 + {2'b00, pop}));
  assign last_addr = (rd_ptr_q == LAST_IDX);
  assign last_beat = (beat_cnt_q == LAST_IDX);

  assign o_valid     = (fifo_count != 2'd0);
  assign o_data      = fifo_head;
  assign o_last      = o_valid & last_beat;
  assign buf_rd_en   = rd_issue;
  assign buf_rd_addr = rd_ptr_q;
  assign busy        = (state_q != IDLE);

  // Next-state logic; done fires on the cycle the final beat is accepted.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (rd_issue && last_addr) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_beat) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read address walker; wraps to zero after the last address so the next frame starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
    end else if (rd_issue) begin
      rd_ptr_q <= last_addr ? '0 : rd_ptr_q + ADDR_W'(1);
    end
  end

  // Accepted-beat counter, kept apart from the read pointer because reads run ahead of beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= last_beat ? '0 : beat_cnt_q + ADDR_W'(1);
    end
  end

  // Marks that a read was issued last cycle and its data lands now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
    end
  end

  stream_skid_fifo #(
    .WIDTH (WORD_W)
  ) u_skid_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (buf_rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
